// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round count, round constants,
// expander FSM states and the round-key type.
package aes_pkg;

    localparam int AES_ROUNDS_128 = 10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic {IDLE, RUN} key_exp_state_e;

    typedef logic [127:0] round_key_t;

    // Indices outside 1..10 return zero so callers never index past the table.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        rcon_of = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (idx == 4'(i)) begin
                rcon_of = RCON[i];
            end
        end
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// Combinational AES-128 key-schedule step: next round key from the current
// key and its round constant.
import aes_pkg::*;

module aes_key_round (
    input  round_key_t  cur,
    input  logic [7:0]  rc,
    output round_key_t  nxt
);

    logic [31:0] rot_w3;
    logic [31:0] sub_w3;
    logic [31:0] t;
    logic [31:0] w0n;
    logic [31:0] w1n;
    logic [31:0] w2n;
    logic [31:0] w3n;

    assign rot_w3 = {cur[23:0], cur[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        sbox u_sbox (
            .x (rot_w3[8*i +: 4]),
            .y (rot_w3[8*i+4 +: 4]),
            .s (sub_w3[8*i +: 8])
        );
    end

    assign t   = sub_w3 ^ {rc, 24'h000000};
    assign w0n = cur[127:96] ^ t;
    assign w1n = cur[95:64]  ^ w0n;
    assign w2n = cur[63:32]  ^ w1n;
    assign w3n = cur[31:0]   ^ w2n;
    assign nxt = {w0n, w1n, w2n, w3n};

endmodule

// File: rtl/sbox.sv
// AES forward S-box cell: multiplicative inverse in GF(2^8) followed by
// the affine transform. x is the low nibble of the input byte, y the high.
module sbox (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] s
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 for nonzero a, and maps zero to zero as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign s = affine(gf_inv({y, x}));

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key expander streaming round keys 0..ROUNDS over valid/yumi.
// Define AES_KEY_STORE_EN to keep every emitted key in a readable register file.
import aes_pkg::*;

module aes_key_expand #(
    parameter int ROUNDS = AES_ROUNDS_128
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [127:0] key_i,
    input  logic         key_v_i,
    output logic         ready_o,
    output logic [127:0] rk_o,
    output logic [3:0]   rk_round_o,
    output logic         rk_v_o,
    input  logic         rk_yumi_i
`ifdef AES_KEY_STORE_EN
   ,input  logic [3:0]   rd_addr_i,
    output logic [127:0] rd_data_o,
    output logic         store_full_o
`endif
);

    if (ROUNDS < 1 || ROUNDS > 10) begin : g_bad_rounds
        $error("aes_key_expand: ROUNDS must be in 1..10");
    end

    key_exp_state_e state;
    round_key_t     nxt;
    logic           last;

    // rk_o doubles as the working key and rk_round_o as the round counter.
    aes_key_round u_round (
        .cur (rk_o),
        .rc  (rcon_of(rk_round_o + 4'd1)),
        .nxt (nxt)
    );

    assign last = (rk_round_o == 4'(ROUNDS));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            ready_o    <= 1'b1;
            rk_v_o     <= 1'b0;
            rk_o       <= '0;
            rk_round_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_v_i) begin
                        state      <= RUN;
                        ready_o    <= 1'b0;
                        rk_v_o     <= 1'b1;
                        rk_o       <= key_i;
                        rk_round_o <= '0;
                    end
                end
                RUN: begin
                    if (rk_yumi_i) begin
                        if (last) begin
                            state   <= IDLE;
                            ready_o <= 1'b1;
                            rk_v_o  <= 1'b0;
                        end else begin
                            rk_o       <= nxt;
                            rk_round_o <= rk_round_o + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AES_KEY_STORE_EN
    round_key_t key_file [0:ROUNDS];

    // Entries are written on the same edge that puts the key on rk_o.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            store_full_o <= 1'b0;
        end else if (state == IDLE && key_v_i) begin
            key_file[0]  <= key_i;
            store_full_o <= 1'b0;
        end else if (state == RUN && rk_yumi_i && !last) begin
            key_file[rk_round_o + 4'd1] <= nxt;
            if (rk_round_o + 4'd1 == 4'(ROUNDS)) begin
                store_full_o <= 1'b1;
            end
        end
    end

    assign rd_data_o = (rd_addr_i <= 4'(ROUNDS)) ? key_file[rd_addr_i] : '0;
`endif

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        rk_yumi_i |-> rk_v_o);

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 word-level key expansion
// model plus directed streaming, stall, ignored-key, reset and store scenarios.
module tb_aes_key_expand;

    localparam int R = 10;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

    localparam logic [2047:0] SBOX_HEX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key;
    logic         key_v;
    logic         ready;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_v;
    logic         yumi;
`ifdef AES_KEY_STORE_EN
    logic [3:0]   rd_addr;
    logic [127:0] rd_data;
    logic         store_full;
`endif

    always #5 clk = ~clk;

    aes_key_expand #(.ROUNDS(R)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .key_i        (key),
        .key_v_i      (key_v),
        .ready_o      (ready),
        .rk_o         (rk),
        .rk_round_o   (rk_round),
        .rk_v_o       (rk_v),
        .rk_yumi_i    (yumi)
`ifdef AES_KEY_STORE_EN
       ,.rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .store_full_o (store_full)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- reference model: FIPS-197 word expansion ----------------
    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX_HEX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [31:0] subRot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sb(r[31:24]), sb(r[23:16]), sb(r[15:8]), sb(r[7:0])};
    endfunction

    logic [127:0] sched [0:R];

    function automatic void expandKey(input logic [127:0] k);
        logic [31:0] w [0:4*R+3];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 4*(R+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subRot(t) ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= R; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Cycle model of the streaming protocol, advanced on each active edge.
    logic         m_valid = 1'b0;
    logic         m_run   = 1'b0;
    int           m_round = 0;
    logic [127:0] m_rk    = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b1;
            m_run   <= 1'b0;
            m_round <= 0;
            m_rk    <= '0;
        end else if (!m_run) begin
            if (key_v) begin
                expandKey(key);
                m_run   <= 1'b1;
                m_round <= 0;
                m_rk    <= sched[0];
            end
        end else if (yumi) begin
            if (m_round == R) begin
                m_run <= 1'b0;
            end else begin
                m_round <= m_round + 1;
                m_rk    <= sched[m_round + 1];
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("ready",    128'(ready),    128'(!m_run));
            checkOutput("rk_v",     128'(rk_v),     128'(m_run));
            checkOutput("rk",       rk,             m_rk);
            checkOutput("rk_round", 128'(rk_round), 128'(m_round));
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic rst, input logic kv, input logic [127:0] k, input logic y);
        @(posedge clk);
        #1;
        reset = rst;
        key_v = kv;
        key   = k;
        yumi  = y;
    endtask

    logic [127:0] beat_keys [0:15];
    logic [127:0] fips_seq  [0:R];
    int           beats;

    task automatic runKey(input logic [127:0] k, input int stall_pct, input logic poke);
        logic done;
        done  = 1'b0;
        beats = 0;
        applyStimulus(1'b0, 1'b1, k, 1'b0);
        for (int c = 0; c < 200; c++) begin
            applyStimulus(1'b0, poke && (c % 3 == 1) && (c < 8), ~k, 1'b0);
`ifdef AES_KEY_STORE_EN
            if (c == 0) checkOutput("store_full_clear", 128'(store_full), 128'(0));
`endif
            if (!rk_v) begin
                done = 1'b1;
                break;
            end
            if ($urandom_range(0, 99) >= stall_pct) begin
                yumi = 1'b1;
                checkOutput("beat_round", 128'(rk_round), 128'(beats));
                if (beats < 16) beat_keys[beats] = rk;
                beats++;
            end
        end
        checkOutput("stream_done", 128'(done), 128'(1));
        checkOutput("beat_count", 128'(beats), 128'(R + 1));
        checkOutput("ready_after_last", 128'(ready), 128'(1));
    endtask

    initial begin
        logic found;
        reset = 1'b1;
        key_v = 1'b0;
        key   = '0;
        yumi  = 1'b0;
`ifdef AES_KEY_STORE_EN
        rd_addr = '0;
`endif

        expandKey(128'h0);
        checkOutput("model_zero_r1", sched[1], ZERO_R1);
        expandKey(FIPS_KEY);
        checkOutput("model_fips_r1", sched[1], FIPS_R1);
        checkOutput("model_fips_r10", sched[10], FIPS_R10);

        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("reset_ready", 128'(ready), 128'(1));
        checkOutput("reset_rk_v", 128'(rk_v), 128'(0));
        checkOutput("reset_rk", rk, '0);
        checkOutput("reset_round", 128'(rk_round), 128'(0));

        $display("[TB] FIPS key, continuous yumi");
        runKey(FIPS_KEY, 0, 1'b0);
        for (int i = 0; i <= R; i++) fips_seq[i] = beat_keys[i];
        checkOutput("fips_beat0", fips_seq[0], FIPS_KEY);
        checkOutput("fips_beat1", fips_seq[1], FIPS_R1);
        checkOutput("fips_beat10", fips_seq[10], FIPS_R10);

`ifdef AES_KEY_STORE_EN
        checkOutput("store_full_set", 128'(store_full), 128'(1));
        for (int a = 0; a <= R; a++) begin
            rd_addr = 4'(a);
            #1;
            checkOutput("store_rd", rd_data, fips_seq[a]);
        end
        rd_addr = 4'd10;
        #1;
        checkOutput("store_rd10", rd_data, FIPS_R10);
        rd_addr = 4'd15;
        #1;
        checkOutput("store_rd15", rd_data, '0);
`endif

        $display("[TB] FIPS key, random stalls");
        runKey(FIPS_KEY, 40, 1'b0);
        for (int i = 0; i <= R; i++) checkOutput("stall_seq", beat_keys[i], fips_seq[i]);

        $display("[TB] FIPS key, foreign key offered during RUN");
        runKey(FIPS_KEY, 25, 1'b1);
        for (int i = 0; i <= R; i++) checkOutput("poke_seq", beat_keys[i], fips_seq[i]);

        $display("[TB] reset after round 4 accepted");
        found = 1'b0;
        applyStimulus(1'b0, 1'b1, FIPS_KEY, 1'b0);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            if (!rk_v) break;
            yumi = 1'b1;
            if (rk_round == 4'd4) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("round4_reached", 128'(found), 128'(1));
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("pre_reset_round", 128'(rk_round), 128'(5));
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("abort_rk_v", 128'(rk_v), 128'(0));
        checkOutput("abort_ready", 128'(ready), 128'(1));
        checkOutput("abort_rk", rk, '0);

        $display("[TB] all-zero key after abort");
        runKey(128'h0, 20, 1'b0);
        checkOutput("zero_beat0", beat_keys[0], '0);
        checkOutput("zero_beat1", beat_keys[1], ZERO_R1);

        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
